// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL dynamic phase-shift sequencer.
//   state_t     : sequencer states, also exported on the debug state port
//   SEL_*       : EHXPLLL PHASESEL encodings for the four PLL outputs
//   clog2_min1  : counter width helper that never returns zero
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    STEP_LO   = 3'd2,
    STEP_HI   = 3'd3,
    LOCK_WAIT = 3'd4,
    DONE      = 3'd5,
    ERR       = 3'd6
  } state_t;

  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;
  localparam logic [1:0] SEL_CLKOP  = 2'b11;

  // Width needed to count 0..v-1; at least one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, output resets to 0
//   d     : asynchronous input
//   q     : input re-timed into the clk domain (2-cycle latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequencer for the ECP5 EHXPLLL dynamic phase-shift port. Accepts one
// phase-shift request (output select, direction, step count), issues the
// PHASESEL/PHASEDIR/PHASESTEP sequence with safe setup and pulse timing, then
// waits for the PLL to relock. Runs on the stable 25 MHz PLL reference clock.
//
// Ports:
//   i_clk, i_rst_n      reference clock, async active-low reset
//   i_req_valid/o_req_ready, i_req_sel/dir/steps   request channel
//   o_busy              high whenever the sequencer is not IDLE
//   o_done / o_err      1-cycle completion / lock-timeout pulses
//   i_pll_lock          raw PLL LOCK (asynchronous), o_locked its synced copy
//   o_phasesel, o_phasedir, o_phasestep, o_phaseloadreg   to EHXPLLL
//   o_state             current sequencer state (debug)
//
// Request handshake: a request transfers on a clock edge where
// i_req_valid & o_req_ready are both high. o_req_ready is high only in IDLE,
// so a request held while busy simply stalls until the sequencer returns to
// IDLE; sel/dir/steps are sampled only at that transfer edge.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int STEP_W      = 4,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 4,
  parameter int LOCK_STABLE = 16,
  parameter int LOCK_TO     = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_sel,
  input  logic              i_req_dir,
  input  logic [STEP_W-1:0] i_req_steps,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  input  logic              i_pll_lock,
  output logic              o_locked,
  output logic [1:0]        o_phasesel,
  output logic              o_phasedir,
  output logic              o_phasestep,
  output logic              o_phaseloadreg,
  output logic [2:0]        o_state
);

  localparam int TMR_W = clog2_min1(max3(SETUP_CYC, PULSE_CYC, GAP_CYC));
  localparam int STB_W = clog2_min1(LOCK_STABLE);
  localparam int TO_W  = clog2_min1(LOCK_TO);

  state_t            state, state_n;
  logic [TMR_W-1:0]  tmr, tmr_n;          // shared by SETUP, STEP_LO, STEP_HI
  logic [STEP_W-1:0] step_cnt, step_n;
  logic [STB_W-1:0]  stable_cnt, stable_n;
  logic [TO_W-1:0]   to_cnt, to_n;
  logic [1:0]        sel_n;
  logic              dir_n;
  logic              stable_hit;
  logic              to_hit;

  sync_2ff u_lock_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_pll_lock),
    .q     (o_locked)
  );

  assign o_req_ready    = (state == IDLE);
  assign o_busy         = (state != IDLE);
  assign o_phaseloadreg = 1'b1;
  assign o_state        = state;

  // Stable check uses the pre-increment count, so LOCK_STABLE locked
  // cycles inside LOCK_WAIT are needed before DONE.
  assign stable_hit = o_locked && (stable_cnt == STB_W'(LOCK_STABLE - 1));
  assign to_hit     = (to_cnt == TO_W'(LOCK_TO - 1));

  always_comb begin
    state_n  = state;
    tmr_n    = tmr;
    step_n   = step_cnt;
    stable_n = stable_cnt;
    to_n     = to_cnt;
    sel_n    = o_phasesel;
    dir_n    = o_phasedir;
    unique case (state)
      IDLE: begin
        if (i_req_valid) begin
          sel_n  = i_req_sel;
          dir_n  = i_req_dir;
          step_n = i_req_steps;
          tmr_n  = '0;
          state_n = (i_req_steps == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (tmr == TMR_W'(SETUP_CYC - 1)) begin
          tmr_n   = '0;
          state_n = STEP_LO;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      STEP_LO: begin
        if (tmr == TMR_W'(PULSE_CYC - 1)) begin
          tmr_n   = '0;
          step_n  = step_cnt - 1'b1;
          state_n = STEP_HI;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      STEP_HI: begin
        // The high gap is also kept after the final step so the last
        // PHASESTEP rising edge is settled before lock supervision starts.
        if (tmr == TMR_W'(GAP_CYC - 1)) begin
          tmr_n    = '0;
          stable_n = '0;
          to_n     = '0;
          state_n  = (step_cnt != '0) ? STEP_LO : LOCK_WAIT;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      LOCK_WAIT: begin
        // DONE takes priority when both limits land on the same cycle.
        if (stable_hit) begin
          state_n = DONE;
        end else if (to_hit) begin
          state_n = ERR;
        end else begin
          stable_n = o_locked ? (stable_cnt + 1'b1) : '0;
          to_n     = to_cnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      tmr         <= '0;
      step_cnt    <= '0;
      stable_cnt  <= '0;
      to_cnt      <= '0;
      o_phasesel  <= 2'b00;
      o_phasedir  <= 1'b0;
      o_phasestep <= 1'b1;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_n;
      tmr         <= tmr_n;
      step_cnt    <= step_n;
      stable_cnt  <= stable_n;
      to_cnt      <= to_n;
      o_phasesel  <= sel_n;
      o_phasedir  <= dir_n;
      // Decoded from the next state so the pins are flop outputs that
      // line up exactly with the state they belong to.
      o_phasestep <= (state_n != STEP_LO);
      o_done      <= (state_n == DONE);
      o_err       <= (state_n == ERR);
    end
  end

endmodule
